audio_framer: RTL and testbench
===============================

AUDIO_FRAMER -- requirements
Module: audio_framer

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 512, meaning samples per output frame (power of 2, 8..4096).
REQ-002 SHALL have parameter HOP, default 256, meaning sample advance between consecutive frame starts (power of 2, 1..FRAME_LEN).
REQ-003 SHALL have port clk_in  input  1  the single clock (98.304 MHz audio domain).
REQ-004 SHALL have port rst_n_in  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port audio_data  input  16  signed PCM sample from the microphone stage.
REQ-006 SHALL have port audio_valid  input  1  audio_data valid.
REQ-007 SHALL have port audio_ready  output  1  framer accepts a sample this cycle.
REQ-008 SHALL have port m_axis_tdata  output  16  signed framed sample.
REQ-009 SHALL have port m_axis_tvalid  output  1  m_axis_tdata valid.
REQ-010 SHALL have port m_axis_tready  input  1  downstream (FFT) accepts.
REQ-011 SHALL have port m_axis_tlast  output  1  high on the last sample of each frame.
REQ-012 SHALL have port overrun  output  1  one-cycle pulse when audio_valid is high and audio_ready is low.

Function
REQ-013 SHALL store accepted samples in a circular buffer of depth 2*FRAME_LEN; an input transfer is audio_valid && audio_ready.
REQ-014 SHALL define frame k as accepted samples k*HOP through k*HOP+FRAME_LEN-1, in arrival order.
REQ-015 SHALL track occupancy = write count minus base of the current frame; audio_ready = (occupancy < 2*FRAME_LEN), asserted combinationally from registered counters.
REQ-016 SHALL implement states IDLE (occupancy < FRAME_LEN), STREAM (emitting current frame) and ADVANCE (one cycle: base += HOP).
REQ-017 SHALL transition IDLE->STREAM when occupancy >= FRAME_LEN; STREAM->ADVANCE on the tlast handshake; ADVANCE->STREAM if occupancy-HOP >= FRAME_LEN, else ADVANCE->IDLE.
REQ-018 SHALL have a one-cycle buffer read latency; the first tvalid of a frame rises no earlier than 2 cycles after the sample completing it is accepted.
REQ-019 SHALL hold m_axis_tdata, m_axis_tvalid and m_axis_tlast stable while tvalid && !tready; transfer = tvalid && tready.
REQ-020 SHALL sustain one output sample per cycle within a frame while m_axis_tready stays high (skid or prefetch register).
REQ-021 SHALL keep accepting input during STREAM and ADVANCE if occupancy permits; a simultaneous write and frame advance in one cycle SHALL update occupancy by +1-HOP.
REQ-022 SHALL wrap all buffer addresses modulo 2*FRAME_LEN; counters SHALL be wide enough that wrap never aliases full with empty.
REQ-023 SHALL assert m_axis_tlast only on frame sample index FRAME_LEN-1.
REQ-024 SHALL, when HOP == FRAME_LEN, produce non-overlapping consecutive frames.

Reset
REQ-025 SHALL, on rst_n_in low, immediately clear all counters, set state IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, overrun=0, audio_ready=1 after release.
REQ-026 SHALL, on reset mid-frame, discard the partial frame and buffered samples; the first frame after release starts with the first sample accepted after release.
REQ-027 SHALL not clear buffer memory contents on reset.

Configuration
REQ-028 SHALL, with macro AUDIO_FRAMER_DC_BLOCK_EN defined, subtract a running mean before storage: y = sat16(x - m), m_next = m + ((x - m) >>> 8), m a 24-bit signed accumulator (16.8 format) reset to 0, updated on each input transfer; stored sample = y.
REQ-029 SHALL, without AUDIO_FRAMER_DC_BLOCK_EN, store audio_data unmodified; no accumulator logic present.

Verification
REQ-030 SHALL verify (FRAME_LEN=8, HOP=4, DC block off) ramp 0,1,2,...,15 input, tready=1 -> frames 0..7 (tlast on 7), 4..11 (tlast on 11), 8..15 (tlast on 15).
REQ-031 SHALL verify (FRAME_LEN=8, HOP=8) 16-sample ramp -> frames 0..7 and 8..15, no overlap, exactly two tlast pulses.
REQ-032 SHALL verify m_axis_tready held low from reset, continuous audio_valid -> audio_ready drops after exactly 16 accepted samples, overrun pulses each following cycle, tdata stays 0 held until tready rises.
REQ-033 SHALL verify random tready (50%) with ramp input -> output sequence identical to REQ-030, no sample duplicated or skipped.
REQ-034 SHALL verify rst_n_in asserted after 5th output sample of a frame -> tvalid low asynchronously; after release input 100..107 yields frame 100..107.
REQ-035 SHALL verify (DC block on) constant input 1000 for 4096 samples -> output magnitude decays below 8 by the last frame; input -32768 step from m=+32767·256 saturates to -32768, not wrap.

Source files
------------

// File: rtl/audio_framer.sv
// rtl/audio_framer.sv - overlapping-frame audio framer with AXI-Stream-style output
// Purpose: stores accepted PCM samples in a circular buffer of 2*FRAME_LEN entries
//   and streams frames of FRAME_LEN samples whose start points advance by HOP.
// Ports:
//   clk_in, rst_n_in              - clock, asynchronous active-low reset
//   audio_data/valid/ready        - input sample handshake
//   m_axis_tdata/tvalid/tready/tlast - framed output stream
//   overrun                       - high while a sample is offered but not accepted
// Option macro: AUDIO_FRAMER_DC_BLOCK_EN - subtract a running mean before storage.
module audio_framer #(
  parameter int FRAME_LEN = 512,
  parameter int HOP       = 256
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic signed [15:0] audio_data,
  input  logic               audio_valid,
  output logic               audio_ready,
  output logic signed [15:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               overrun
);
  localparam int DEPTH = 2 * FRAME_LEN;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;               // extra bit keeps full distinct from empty
  localparam int IW    = $clog2(FRAME_LEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_ADVANCE} state_t;
  state_t r_state, w_state_next;

  logic [CW-1:0]      r_wr_cnt, r_base, w_occ;
  logic [IW-1:0]      r_issue;
  logic signed [15:0] r_mem [DEPTH];
  logic signed [15:0] r_mem_q;
  logic               r_inflight, r_inflight_last;
  logic signed [15:0] r_skid_data;
  logic               r_skid_valid, r_skid_last;
  logic signed [15:0] r_tdata;
  logic               r_tvalid, r_tlast;
  logic               w_wr_en, w_pop, w_issue, w_last_xfer;
  logic [1:0]         w_slots;
  logic [AW-1:0]      w_rd_addr;
  logic signed [15:0] w_store;

  assign w_occ         = r_wr_cnt - r_base;
  assign audio_ready   = (w_occ < CW'(DEPTH));
  assign w_wr_en       = audio_valid && audio_ready;
  assign overrun       = audio_valid && !audio_ready;
  assign w_pop         = r_tvalid && m_axis_tready;
  assign w_last_xfer   = w_pop && r_tlast;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;

  // Output register + skid register give two slots; a read is issued only if the
  // sample it returns next cycle is guaranteed a slot, counting the one in flight.
  assign w_slots   = {1'b0, r_tvalid} + {1'b0, r_skid_valid} + {1'b0, r_inflight};
  assign w_issue   = (r_state == S_STREAM) && (r_issue < IW'(FRAME_LEN)) &&
                     ((w_slots - {1'b0, w_pop}) < 2'd2);
  assign w_rd_addr = r_base[AW-1:0] + AW'(r_issue);

`ifdef AUDIO_FRAMER_DC_BLOCK_EN
  // Running mean in 16.8: integer part r_mean[23:8] is subtracted from the sample.
  logic signed [23:0] r_mean;
  logic signed [24:0] w_diff;
  logic signed [16:0] w_y_wide;

  always_comb begin
    w_diff   = {audio_data[15], audio_data, 8'd0} - {r_mean[23], r_mean};
    w_y_wide = {audio_data[15], audio_data} - {r_mean[23], r_mean[23:8]};
    if (w_y_wide[16] != w_y_wide[15]) begin
      w_store = w_y_wide[16] ? 16'sh8000 : 16'sh7fff;
    end else begin
      w_store = w_y_wide[15:0];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_mean <= '0;
    end else if (w_wr_en) begin
      r_mean <= r_mean + 24'(w_diff >>> 8);
    end
  end
`else
  assign w_store = audio_data;
`endif

  // Buffer memory is deliberately left out of reset.
  always_ff @(posedge clk_in) begin
    if (w_wr_en) r_mem[r_wr_cnt[AW-1:0]] <= w_store;
    if (w_issue) r_mem_q <= r_mem[w_rd_addr];
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_occ >= CW'(FRAME_LEN)) w_state_next = S_STREAM;
      S_STREAM:  if (w_last_xfer) w_state_next = S_ADVANCE;
      S_ADVANCE: w_state_next = ((w_occ - CW'(HOP)) >= CW'(FRAME_LEN)) ? S_STREAM : S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state  <= S_IDLE;
      r_wr_cnt <= '0;
      r_base   <= '0;
      r_issue  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_wr_en) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (r_state == S_ADVANCE) r_base <= r_base + CW'(HOP);
      if (r_state != S_STREAM) r_issue <= '0;
      else if (w_issue) r_issue <= r_issue + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_skid_valid    <= 1'b0;
      r_skid_last     <= 1'b0;
      r_skid_data     <= '0;
      r_tvalid        <= 1'b0;
      r_tlast         <= 1'b0;
      r_tdata         <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_inflight_last <= (r_issue == IW'(FRAME_LEN - 1));
      if (!r_tvalid || m_axis_tready) begin
        if (r_skid_valid) begin
          r_tdata      <= r_skid_data;
          r_tlast      <= r_skid_last;
          r_tvalid     <= 1'b1;
          r_skid_valid <= r_inflight;
          r_skid_data  <= r_mem_q;
          r_skid_last  <= r_inflight_last;
        end else begin
          r_tvalid <= r_inflight;
          r_tlast  <= r_inflight && r_inflight_last;
          if (r_inflight) r_tdata <= r_mem_q;
        end
      end else if (r_inflight) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= r_mem_q;
        r_skid_last  <= r_inflight_last;
      end
    end
  end
endmodule

// File: tb/tb_audio_framer.sv
// tb/tb_audio_framer.sv - bench for audio_framer with HOP=4 and HOP=8 instances
module tb_audio_framer;
  localparam int FL = 8;
  localparam int HOPS [2] = '{4, 8};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic signed [15:0] din;
  logic               vin;
  logic               rdy [2];
  logic signed [15:0] td  [2];
  logic               tv  [2];
  logic               tr  [2];
  logic               tl  [2];
  logic               ov  [2];

  int n_chk = 0;
  int n_fail = 0;

  int acc   [2][$];
  int nout  [2];
  int nlast [2];
  int mean  [2];
  int lastv [2];
  int minv  [2];
  bit stall [2];

  audio_framer #(.FRAME_LEN(FL), .HOP(4)) dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .audio_data(din), .audio_valid(vin),
    .audio_ready(rdy[0]), .m_axis_tdata(td[0]), .m_axis_tvalid(tv[0]),
    .m_axis_tready(tr[0]), .m_axis_tlast(tl[0]), .overrun(ov[0]));

  audio_framer #(.FRAME_LEN(FL), .HOP(8)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .audio_data(din), .audio_valid(vin),
    .audio_ready(rdy[1]), .m_axis_tdata(td[1]), .m_axis_tvalid(tv[1]),
    .m_axis_tready(tr[1]), .m_axis_tlast(tl[1]), .overrun(ov[1]));

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Value the framer should hold for an accepted input sample.
  function automatic int stored(input int x, inout int m);
`ifdef AUDIO_FRAMER_DC_BLOCK_EN
    int y;
    y = x - (m >>> 8);
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    m = m + ((x * 256 - m) >>> 8);
    return y;
`else
    return x;
`endif
  endfunction

  function automatic int frames_for(input int n_acc, input int hop);
    return (n_acc >= FL) ? ((n_acc - FL) / hop + 1) : 0;
  endfunction

  // Reference model: output n of the stream is sample (n/FL)*HOP + n%FL of the
  // accepted sequence, tlast on every FL-th output.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        acc[d].delete();
        nout[d] = 0; nlast[d] = 0; mean[d] = 0;
        lastv[d] = 0; minv[d] = 0; stall[d] = 1'b0;
      end else begin
        if (stall[d]) check($sformatf("hold_tvalid_%0d", d), tv[d], 1);
        if (vin && rdy[d]) acc[d].push_back(stored(int'(din), mean[d]));
        if (tv[d] && tr[d]) begin
          int idx;
          idx = (nout[d] / FL) * HOPS[d] + nout[d] % FL;
          check($sformatf("data_%0d_out%0d", d, nout[d]), td[d],
                (idx < acc[d].size()) ? acc[d][idx] : 32'sh7fffffff);
          check($sformatf("last_%0d_out%0d", d, nout[d]), tl[d],
                (nout[d] % FL) == (FL - 1));
          nlast[d] += int'(tl[d]);
          nout[d]++;
          lastv[d] = int'(td[d]);
          if (int'(td[d]) < minv[d]) minv[d] = int'(td[d]);
        end
        stall[d] = tv[d] && !tr[d];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; vin = 1'b0; tr[0] = 1'b0; tr[1] = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic feed_ramp(input int first, input int count, input bit rnd_ready);
    for (int i = 0; i < count; i++) begin
      din = 16'(first + i); vin = 1'b1;
      if (rnd_ready) begin
        tr[0] = 1'($urandom_range(0, 1)); tr[1] = 1'($urandom_range(0, 1));
      end
      tick(1);
    end
    vin = 1'b0;
  endtask

  task automatic check_counts(input string tag, input int exp_a, input int exp_b);
    check({tag, "_count_a"}, nout[0], exp_a);
    check({tag, "_count_b"}, nout[1], exp_b);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; vin = 1'b0; din = '0; tr[0] = 1'b0; tr[1] = 1'b0;

    // Reset state
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_tvalid_%0d", d), tv[d], 0);
      check($sformatf("rst_tlast_%0d", d), tl[d], 0);
      check($sformatf("rst_tdata_%0d", d), td[d], 0);
      check($sformatf("rst_overrun_%0d", d), ov[d], 0);
    end
    tick(2);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready_a", rdy[0], 1);
    check("rst_ready_b", rdy[1], 1);
    tick(1);

    // Ramp 0..15 with tready high: HOP=4 gives 3 frames, HOP=8 gives 2
    tr[0] = 1'b1; tr[1] = 1'b1;
    feed_ramp(0, 16, 1'b0);
    tick(60);
    check_counts("ramp", 24, 16);
    check("ramp_tlast_a", nlast[0], 3);
    check("ramp_tlast_b", nlast[1], 2);

    // tready low from reset: exactly 16 accepted, then overrun every cycle
    do_reset();
    for (int c = 0; c < 20; c++) begin
      din = 16'(c); vin = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check($sformatf("fill_ready_%0d_c%0d", d, c), rdy[d], c < 16);
        check($sformatf("fill_overrun_%0d_c%0d", d, c), ov[d], c >= 16);
      end
      tick(1);
    end
    vin = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("stall_tvalid_a", tv[0], 1);
      check("stall_tdata_a", td[0], 0);
      check("stall_tdata_b", td[1], 0);
      tick(1);
    end
    tr[0] = 1'b1; tr[1] = 1'b1;
    tick(60);
    check_counts("fill", 24, 16);

    // Random tready with ramp input
    do_reset();
    feed_ramp(0, 16, 1'b1);
    for (int c = 0; c < 150; c++) begin
      tr[0] = 1'($urandom_range(0, 1)); tr[1] = 1'($urandom_range(0, 1));
      tick(1);
    end
    tr[0] = 1'b1; tr[1] = 1'b1;
    tick(40);
    check_counts("rnd_ready", 24, 16);
    check("rnd_ready_tlast_a", nlast[0], 3);

    // Reset after the 5th output sample, then a fresh frame 100..107
    do_reset();
    tr[0] = 1'b1; tr[1] = 1'b1;
    feed_ramp(0, 8, 1'b0);
    k = 0;
    while (nout[0] < 5 && k < 100) begin
      tick(1);
      k++;
    end
    check("wait_5th_output", nout[0] >= 5, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_tvalid_a", tv[0], 0);
    check("async_rst_tvalid_b", tv[1], 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    tr[0] = 1'b1; tr[1] = 1'b1;
    feed_ramp(100, 8, 1'b0);
    tick(40);
    check_counts("post_rst", 8, 8);

    // Random data, random valid, random tready
    do_reset();
    for (int c = 0; c < 300; c++) begin
      din = 16'($urandom); vin = ($urandom_range(0, 9) < 7);
      tr[0] = 1'($urandom_range(0, 1)); tr[1] = 1'($urandom_range(0, 1));
      tick(1);
    end
    vin = 1'b0; tr[0] = 1'b1; tr[1] = 1'b1;
    tick(80);
    check_counts("random", frames_for(acc[0].size(), 4) * FL,
                 frames_for(acc[1].size(), 8) * FL);

`ifdef AUDIO_FRAMER_DC_BLOCK_EN
    // Constant input decays toward zero
    do_reset();
    tr[0] = 1'b1; tr[1] = 1'b1;
    din = 16'sd1000; vin = 1'b1;
    tick(4096);
    vin = 1'b0;
    tick(60);
    for (int d = 0; d < 2; d++)
      check($sformatf("dc_decay_%0d", d), (lastv[d] < 8) && (lastv[d] > -8), 1);

    // Negative full-scale step from a near full-scale mean saturates
    do_reset();
    tr[0] = 1'b1; tr[1] = 1'b1;
    din = 16'sh7fff; vin = 1'b1;
    tick(3000);
    din = 16'sh8000;
    tick(40);
    vin = 1'b0;
    tick(80);
    for (int d = 0; d < 2; d++)
      check($sformatf("dc_saturate_%0d", d), minv[d], -32768);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
